btn_scan: RTL and testbench

BTN_SCAN -- requirements
Module: btn_scan

---
 rtl/btn_scan.sv | 160 ++++++++++++++++
 tb/tb_btn_scan.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_scan.sv
// ---------------------------------------------------------------------------
// btn_scan
//
// Debounces n button channels with a single shared up/down filter. A
// prescaler paces the scan, and on each service slot one channel (selected
// by a scan pointer) has its saturating counter nudged towards its raw input
// level. The debounced output flips only when the counter reaches an end
// stop, giving hysteresis. Every flip of a debounced output is reported as
// one event on a valid/ready handshake. While an event is refused by the
// consumer, the whole scan freezes, so no transition can ever be lost.
//
// Parameters
//   n    number of button channels (n >= 2)
//   len  filter length in services per channel (len >= 2)
//   div  clk cycles per service slot (div >= 1)
//
// Ports
//   clk       single clock, all logic on its rising edge
//   rst       synchronous active-high reset
//   in        raw button levels, already synchronised to clk
//   out       debounced button levels
//   ev_valid  an event is held on ev_chan / ev_press
//   ev_ready  consumer accepts the held event
//   ev_chan   channel index of the held event
//   ev_press  1 = press (out rose), 0 = release (out fell)
// ---------------------------------------------------------------------------
module btn_scan #(
  parameter int n   = 8,
  parameter int len = 64,
  parameter int div = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [n-1:0]         in,
  output logic [n-1:0]         out,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [$clog2(n)-1:0] ev_chan,
  output logic                 ev_press
);

  localparam int CW = $clog2(len);
  localparam int PW = $clog2(n);
  // With div == 1 the prescaler degenerates to a constant zero, but it still
  // needs at least one bit to exist as a register.
  localparam int SW = (div > 1) ? $clog2(div) : 1;

  localparam logic [CW-1:0] CTR_MAX   = CW'(len - 1);
  localparam logic [PW-1:0] PTR_MAX   = PW'(n - 1);
  localparam logic [SW-1:0] SCALE_MAX = SW'(div - 1);

  logic [CW-1:0] ctr_q [n];
  logic [CW-1:0] ctr_d [n];
  logic [n-1:0]  out_q, out_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] scale_q, scale_d;
  logic          ev_valid_q, ev_valid_d;
  logic [PW-1:0] ev_chan_q, ev_chan_d;
  logic          ev_press_q, ev_press_d;

  logic          blocked;
  logic          service;
  logic          cur_in;
  logic          cur_out;
  logic          new_out;
  logic          fire;
  logic [CW-1:0] cur_ctr;
  logic [CW-1:0] new_ctr;

  // Filter step for the channel under the scan pointer. These values are only
  // committed on a service cycle; outside of one they are simply ignored.
  always_comb begin
    blocked = ev_valid_q & ~ev_ready;
    service = ~blocked & (scale_q == SCALE_MAX);

    cur_in  = in[ptr_q];
    cur_ctr = ctr_q[ptr_q];
    cur_out = out_q[ptr_q];

    new_ctr = cur_ctr;
    if (cur_in && (cur_ctr != CTR_MAX)) begin
      new_ctr = cur_ctr + 1'b1;
    end else if (!cur_in && (cur_ctr != '0)) begin
      new_ctr = cur_ctr - 1'b1;
    end

    // Output only moves when the counter arrives at an end stop, so a counter
    // already sitting at a stop (saturating) never produces a new transition.
    new_out = cur_out;
    if ((new_ctr == CTR_MAX) && (cur_ctr != CTR_MAX)) begin
      new_out = 1'b1;
    end else if ((new_ctr == '0) && (cur_ctr != '0)) begin
      new_out = 1'b0;
    end

    fire = service & (new_out != cur_out);
  end

  // Next-state for the scan, the per-channel storage and the event holder.
  // A service can never happen while the holder is blocked, so a newly fired
  // event only ever replaces an empty or just-accepted slot.
  always_comb begin
    ctr_d      = ctr_q;
    out_d      = out_q;
    ptr_d      = ptr_q;
    scale_d    = scale_q;
    ev_valid_d = ev_valid_q;
    ev_chan_d  = ev_chan_q;
    ev_press_d = ev_press_q;

    if (!blocked) begin
      scale_d = (scale_q == SCALE_MAX) ? '0 : scale_q + 1'b1;
    end

    if (service) begin
      ctr_d[ptr_q] = new_ctr;
      out_d[ptr_q] = new_out;
      ptr_d        = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
    end

    if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end

    if (fire) begin
      ev_valid_d = 1'b1;
      ev_chan_d  = ptr_q;
      ev_press_d = new_out;
    end
  end

  // State registers; reset wins over any handshake or service in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < n; k++) begin
        ctr_q[k] <= '0;
      end
      out_q      <= '0;
      ptr_q      <= '0;
      scale_q    <= '0;
      ev_valid_q <= 1'b0;
      ev_chan_q  <= '0;
      ev_press_q <= 1'b0;
    end else begin
      ctr_q      <= ctr_d;
      out_q      <= out_d;
      ptr_q      <= ptr_d;
      scale_q    <= scale_d;
      ev_valid_q <= ev_valid_d;
      ev_chan_q  <= ev_chan_d;
      ev_press_q <= ev_press_d;
    end
  end

  assign out      = out_q;
  assign ev_valid = ev_valid_q;
  assign ev_chan  = ev_chan_q;
  assign ev_press = ev_press_q;

endmodule

// File: tb/tb_btn_scan.sv
// ---------------------------------------------------------------------------
// tb_btn_scan
//
// Bench for btn_scan with n=4, len=4, div=1. A behavioural reference model
// runs alongside the design and pushes every expected event into a queue;
// each accepted handshake pops and compares one entry. Scenario tasks add
// hand-derived cycle-exact checks on top of that.
// ---------------------------------------------------------------------------
module tb_btn_scan;

  localparam int N   = 4;
  localparam int LEN = 4;
  localparam int DIV = 1;

  typedef logic [2:0] ev_t;  // {press, chan[1:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = '0;
  logic [3:0] btn_out;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [1:0] ev_chan;
  logic       ev_press;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state, always equal to the design state after the most
  // recent rising edge.
  int         m_ctr [N] = '{default: 0};
  logic [3:0] m_out   = '0;
  int         m_ptr   = 0;
  int         m_presc = 0;
  logic       m_valid = 1'b0;
  logic [1:0] m_chan  = '0;
  logic       m_press = 1'b0;

  ev_t exp_q  [$];
  ev_t ev_log [$];

  btn_scan #(
    .n   (N),
    .len (LEN),
    .div (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (btn_in),
    .out      (btn_out),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_chan  (ev_chan),
    .ev_press (ev_press)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: compare against the model, score accepted events,
  // then advance the model using the inputs the next rising edge will see.
  always @(negedge clk) begin
    int   c;
    int   ch;
    logic fire;
    ev_t  e;

    vectors++;
    if (btn_out !== m_out) begin
      miscompares++;
      $display("[TB] FAIL lockstep_out: got %b expected %b at %0t", btn_out, m_out, $time);
    end
    vectors++;
    if (ev_valid !== m_valid) begin
      miscompares++;
      $display("[TB] FAIL lockstep_valid: got %b expected %b at %0t", ev_valid, m_valid, $time);
    end
    if (m_valid) begin
      vectors++;
      if ({ev_press, ev_chan} !== {m_press, m_chan}) begin
        miscompares++;
        $display("[TB] FAIL lockstep_event: got press=%b chan=%0d expected press=%b chan=%0d at %0t",
                 ev_press, ev_chan, m_press, m_chan, $time);
      end
    end

    if (!rst && (ev_valid === 1'b1) && ev_ready) begin
      ev_log.push_back({ev_press, ev_chan});
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL scoreboard_unexpected: got press=%b chan=%0d expected no event at %0t",
                 ev_press, ev_chan, $time);
      end else begin
        e = exp_q.pop_front();
        if ({ev_press, ev_chan} !== e) begin
          miscompares++;
          $display("[TB] FAIL scoreboard_event: got press=%b chan=%0d expected press=%b chan=%0d at %0t",
                   ev_press, ev_chan, e[2], e[1:0], $time);
        end
      end
    end

    if (rst) begin
      for (int k = 0; k < N; k++) m_ctr[k] = 0;
      m_out   = '0;
      m_ptr   = 0;
      m_presc = 0;
      m_valid = 1'b0;
      m_chan  = '0;
      m_press = 1'b0;
      exp_q.delete();
    end else begin
      fire = 1'b0;
      ch   = m_ptr;
      if (!(m_valid && !ev_ready)) begin
        if (m_presc == DIV - 1) begin
          c = m_ctr[ch];
          if (btn_in[ch] && c < LEN - 1) c++;
          else if (!btn_in[ch] && c > 0) c--;
          if (c == LEN - 1 && !m_out[ch]) begin
            m_out[ch] = 1'b1;
            fire = 1'b1;
          end else if (c == 0 && m_out[ch]) begin
            m_out[ch] = 1'b0;
            fire = 1'b1;
          end
          m_ctr[ch] = c;
          m_ptr     = (m_ptr + 1) % N;
          m_presc   = 0;
        end else begin
          m_presc++;
        end
      end
      if (m_valid && ev_ready) m_valid = 1'b0;
      if (fire) begin
        m_valid = 1'b1;
        m_chan  = 2'(ch);
        m_press = m_out[ch];
        exp_q.push_back({m_press, m_chan});
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Pulse reset for one edge with the given inputs already applied; the
  // next rising edge is the first service of channel 0.
  task automatic do_reset(input logic [3:0] pattern, input logic ready);
    rst      = 1'b1;
    btn_in   = pattern;
    ev_ready = ready;
    tick(1);
    rst = 1'b0;
    ev_log.delete();
  endtask

  task automatic test_reset;
    tick(2);
    vectors++;
    if ({btn_out, ev_valid, ev_chan, ev_press} !== 8'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got out=%b v=%b c=%0d p=%b expected all zero",
               btn_out, ev_valid, ev_chan, ev_press);
    end
  endtask

  task automatic test_press;
    do_reset(4'b0001, 1'b1);
    tick(8);
    vectors++;
    if ({btn_out, ev_valid} !== 5'b0000_0) begin
      miscompares++;
      $display("[TB] FAIL press_early: got out=%b v=%b expected out=0000 v=0", btn_out, ev_valid);
    end
    tick(1);
    vectors++;
    if ({btn_out, ev_valid, ev_chan, ev_press} !== {4'b0001, 1'b1, 2'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL press_fire: got out=%b v=%b c=%0d p=%b expected out=0001 v=1 c=0 p=1",
               btn_out, ev_valid, ev_chan, ev_press);
    end
    tick(1);
    vectors++;
    if (ev_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL press_accept: got v=%b expected v=0", ev_valid);
    end
  endtask

  task automatic test_glitch;
    tick(2);
    btn_in = 4'b0000;
    tick(1);
    btn_in = 4'b0001;
    vectors++;
    if ({btn_out, ev_valid} !== 5'b0001_0) begin
      miscompares++;
      $display("[TB] FAIL glitch_dip: got out=%b v=%b expected out=0001 v=0", btn_out, ev_valid);
    end
    tick(4);
    vectors++;
    if ({btn_out, ev_valid} !== 5'b0001_0) begin
      miscompares++;
      $display("[TB] FAIL glitch_recover: got out=%b v=%b expected out=0001 v=0", btn_out, ev_valid);
    end
    vectors++;
    if (ev_log.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL glitch_events: got %0d expected 1", ev_log.size());
    end
  endtask

  task automatic test_backpressure;
    do_reset(4'b0011, 1'b0);
    tick(9);
    vectors++;
    if ({btn_out, ev_valid, ev_chan, ev_press} !== {4'b0001, 1'b1, 2'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL bp_hold0: got out=%b v=%b c=%0d p=%b expected out=0001 v=1 c=0 p=1",
               btn_out, ev_valid, ev_chan, ev_press);
    end
    tick(5);
    vectors++;
    if ({btn_out, ev_valid, ev_chan, ev_press} !== {4'b0001, 1'b1, 2'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL bp_stall: got out=%b v=%b c=%0d p=%b expected out=0001 v=1 c=0 p=1",
               btn_out, ev_valid, ev_chan, ev_press);
    end
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    vectors++;
    if ({btn_out, ev_valid, ev_chan, ev_press} !== {4'b0011, 1'b1, 2'd1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL bp_next: got out=%b v=%b c=%0d p=%b expected out=0011 v=1 c=1 p=1",
               btn_out, ev_valid, ev_chan, ev_press);
    end
    tick(3);
    vectors++;
    if ({ev_valid, ev_chan} !== {1'b1, 2'd1}) begin
      miscompares++;
      $display("[TB] FAIL bp_hold1: got v=%b c=%0d expected v=1 c=1", ev_valid, ev_chan);
    end
    ev_ready = 1'b1;
    tick(1);
    vectors++;
    if (ev_valid !== 1'b0 || ev_log.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL bp_drain: got v=%b events=%0d expected v=0 events=2", ev_valid, ev_log.size());
    end
  endtask

  task automatic test_back_to_back;
    do_reset(4'b0011, 1'b1);
    tick(9);
    vectors++;
    if ({ev_valid, ev_chan} !== {1'b1, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got v=%b c=%0d expected v=1 c=0", ev_valid, ev_chan);
    end
    tick(1);
    vectors++;
    if ({ev_valid, ev_chan, ev_press} !== {1'b1, 2'd1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got v=%b c=%0d p=%b expected v=1 c=1 p=1", ev_valid, ev_chan, ev_press);
    end
    tick(1);
    vectors++;
    if (ev_valid !== 1'b0 || btn_out !== 4'b0011) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle: got v=%b out=%b expected v=0 out=0011", ev_valid, btn_out);
    end
    vectors++;
    if (ev_log.size() != 2 || ev_log[0] !== 3'b100 || ev_log[1] !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d events expected 2 (press ch0, press ch1)", ev_log.size());
    end
  endtask

  task automatic test_reset_mid;
    do_reset(4'b0010, 1'b0);
    tick(11);
    vectors++;
    if ({ev_valid, ev_chan, ev_press} !== {1'b1, 2'd1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_pre: got v=%b c=%0d p=%b expected v=1 c=1 p=1", ev_valid, ev_chan, ev_press);
    end
    btn_in = 4'b0001;
    rst    = 1'b1;
    tick(1);
    vectors++;
    if ({btn_out, ev_valid, ev_chan, ev_press} !== 8'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_clear: got out=%b v=%b c=%0d p=%b expected all zero",
               btn_out, ev_valid, ev_chan, ev_press);
    end
    rst      = 1'b0;
    ev_ready = 1'b1;
    tick(8);
    vectors++;
    if (btn_out !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL rstmid_early: got out=%b expected 0000", btn_out);
    end
    tick(1);
    vectors++;
    if ({btn_out, ev_valid, ev_chan} !== {4'b0001, 1'b1, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_ch0: got out=%b v=%b c=%0d expected out=0001 v=1 c=0",
               btn_out, ev_valid, ev_chan);
    end
  endtask

  task automatic test_all_channels;
    ev_t want;
    do_reset(4'b1111, 1'b1);
    tick(20);
    vectors++;
    if (btn_out !== 4'b1111) begin
      miscompares++;
      $display("[TB] FAIL all_pressed: got out=%b expected 1111", btn_out);
    end
    btn_in = 4'b0000;
    tick(16);
    vectors++;
    if (btn_out !== 4'b0000 || ev_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL all_released: got out=%b v=%b expected out=0000 v=0", btn_out, ev_valid);
    end
    vectors++;
    if (ev_log.size() != 8) begin
      miscompares++;
      $display("[TB] FAIL all_count: got %0d events expected 8", ev_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        want = {(i < 4) ? 1'b1 : 1'b0, 2'(i % 4)};
        vectors++;
        if (ev_log[i] !== want) begin
          miscompares++;
          $display("[TB] FAIL all_order[%0d]: got press=%b chan=%0d expected press=%b chan=%0d",
                   i, ev_log[i][2], ev_log[i][1:0], want[2], want[1:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_all_channels();
    tick(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
